// File: rtl/namuru_evt_pkg.sv
// -----------------------------------------------------------------------------
// namuru_evt_pkg
// Shared constants for the Namuru event controller: CSR word indices,
// CTRL bit positions and the OVERRUN saturation limit.
// Optional feature macro used by the bank: NAMURU_EVT_POL_EN.
// -----------------------------------------------------------------------------
package namuru_evt_pkg;

    // CSR word indices (csr_a[3:0])
    localparam logic [3:0] REG_CTRL      = 4'd0;
    localparam logic [3:0] REG_MASK      = 4'd1;
    localparam logic [3:0] REG_PENDING   = 4'd2;
    localparam logic [3:0] REG_OVERRUN   = 4'd3;
    localparam logic [3:0] REG_TIMESTAMP = 4'd4;
    localparam logic [3:0] REG_POL       = 4'd5;
    localparam logic [3:0] REG_EVTS_BASE = 4'd8;

    // CTRL bit positions
    localparam int unsigned CTRL_ENABLE   = 0;
    localparam int unsigned CTRL_TS_CLEAR = 1;

    localparam logic [15:0] OVERRUN_MAX = 16'hFFFF;

endpackage

// File: rtl/namuru_evt_sync.sv
// -----------------------------------------------------------------------------
// namuru_evt_sync
// DEPTH-stage level synchronizer followed by an edge detector for one event
// source. The detected edge is a one-cycle pulse.
//   sys_clk    in  system clock
//   sys_rst    in  synchronous active-high reset (clears all stages)
//   ev_in      in  raw asynchronous event level
//   pol        in  active edge select: 0 rising, 1 falling
//   edge_pulse out one-cycle pulse on the selected edge of the synced level
// -----------------------------------------------------------------------------
module namuru_evt_sync #(
    parameter int unsigned DEPTH = 4
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic ev_in,
    input  logic pol,
    output logic edge_pulse
);

    logic [DEPTH-1:0] stages;
    logic             prev;
    logic             synced;

    assign synced = stages[DEPTH-1];

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            stages <= '0;
            prev   <= 1'b0;
        end else begin
            stages <= {stages[DEPTH-2:0], ev_in};
            prev   <= synced;
        end
    end

    // synced and prev are compared under the same polarity, so a POL change
    // on a steady level never produces a pulse.
    assign edge_pulse = pol ? (prev & ~synced) : (synced & ~prev);

endmodule

// File: rtl/namuru_evt_ctrl.sv
// -----------------------------------------------------------------------------
// namuru_evt_ctrl
// sys_clk-domain event controller for the Namuru GPS correlator. Each raw
// event level is synchronized and edge-detected; an edge sets a pending flag,
// latches the free-running timestamp and may bump the saturating overrun
// counter. A single maskable level IRQ is exposed through a CSR slave.
// Optional feature: define NAMURU_EVT_POL_EN for per-source edge polarity (POL).
//   sys_clk  in  system clock
//   sys_rst  in  synchronous active-high reset
//   csr_a    in  CSR address ([13:10] bank, [3:0] word index)
//   csr_we   in  CSR write strobe
//   csr_di   in  CSR write data
//   csr_do   out CSR read data, registered, 0 when bank not selected
//   ev_in    in  raw asynchronous event levels
//   irq      out registered level interrupt = |(PENDING & MASK)
// -----------------------------------------------------------------------------
module namuru_evt_ctrl
    import namuru_evt_pkg::*;
#(
    parameter logic [3:0]  csr_addr = 4'h0,
    parameter int unsigned NEV      = 2,
    parameter int unsigned DEPTH    = 4
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    input  logic [13:0]    csr_a,
    input  logic           csr_we,
    input  logic [31:0]    csr_di,
    output logic [31:0]    csr_do,
    input  logic [NEV-1:0] ev_in,
    output logic           irq
);

    logic           enable;
    logic [NEV-1:0] mask;
    logic [NEV-1:0] pending;
    logic [15:0]    overrun;
    logic [31:0]    timestamp;
    logic [31:0]    evts [NEV];
    logic [NEV-1:0] pol_eff;

    logic           sel;
    logic [3:0]     idx;
    logic           wr;
    logic [NEV-1:0] edges;
    logic [NEV-1:0] evs;
    logic [NEV-1:0] clr;
    logic           ovf;
    logic           ts_clr;
    logic [31:0]    rd;

    logic           unused_bits;
    assign unused_bits = ^{csr_a[9:4], csr_di};

    assign sel = (csr_a[13:10] == csr_addr);
    assign idx = csr_a[3:0];
    assign wr  = csr_we & sel;

`ifdef NAMURU_EVT_POL_EN
    logic [NEV-1:0] pol;
    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            pol <= '0;
        else if (wr && idx == REG_POL)
            pol <= csr_di[NEV-1:0];
    end
    assign pol_eff = pol;
`else
    assign pol_eff = '0;
`endif

    for (genvar k = 0; k < NEV; k++) begin : g_sync
        namuru_evt_sync #(.DEPTH(DEPTH)) u_sync (
            .sys_clk    (sys_clk),
            .sys_rst    (sys_rst),
            .ev_in      (ev_in[k]),
            .pol        (pol_eff[k]),
            .edge_pulse (edges[k])
        );
    end

    always_comb begin
        clr    = (wr && idx == REG_PENDING) ? csr_di[NEV-1:0] : '0;
        evs    = enable ? edges : '0;
        // A set in the same cycle as its own W1C is not an overrun; several
        // sources overrunning together count once.
        ovf    = |(evs & pending & ~clr);
        ts_clr = wr && (idx == REG_CTRL) && csr_di[CTRL_TS_CLEAR];

        rd = '0;
        case (idx)
            REG_CTRL:      rd[CTRL_ENABLE] = enable;
            REG_MASK:      rd[NEV-1:0]     = mask;
            REG_PENDING:   rd[NEV-1:0]     = pending;
            REG_OVERRUN:   rd[15:0]        = overrun;
            REG_TIMESTAMP: rd              = timestamp;
`ifdef NAMURU_EVT_POL_EN
            REG_POL:       rd[NEV-1:0]     = pol;
`endif
            default: begin
                for (int unsigned k = 0; k < NEV; k++) begin
                    if (idx == REG_EVTS_BASE + 4'(k))
                        rd = evts[k];
                end
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            enable    <= 1'b0;
            mask      <= '0;
            pending   <= '0;
            overrun   <= '0;
            timestamp <= '0;
            for (int unsigned k = 0; k < NEV; k++)
                evts[k] <= '0;
            csr_do    <= '0;
            irq       <= 1'b0;
        end else begin
            timestamp <= ts_clr ? '0 : timestamp + 32'd1;

            if (wr && idx == REG_CTRL)
                enable <= csr_di[CTRL_ENABLE];
            if (wr && idx == REG_MASK)
                mask <= csr_di[NEV-1:0];

            pending <= (pending & ~clr) | evs;

            // Latch the pre-increment / pre-clear timestamp.
            for (int unsigned k = 0; k < NEV; k++) begin
                if (evs[k])
                    evts[k] <= timestamp;
            end

            if (wr && idx == REG_OVERRUN)
                overrun <= '0;
            else if (ovf && overrun != OVERRUN_MAX)
                overrun <= overrun + 16'd1;

            csr_do <= sel ? rd : '0;
            irq    <= |(pending & mask);
        end
    end

endmodule

// File: tb/tb_namuru_evt_ctrl.sv
module tb_namuru_evt_ctrl;
    import namuru_evt_pkg::*;

    localparam int unsigned NEV   = 2;
    localparam int unsigned DEPTH = 4;
    localparam logic [3:0]  BANK  = 4'h3;

    logic           clk;
    logic           rst;
    logic [13:0]    a;
    logic           we;
    logic [31:0]    di;
    logic [31:0]    csr_do;
    logic [NEV-1:0] ev;
    logic           irq;

    int n_cmp = 0;
    int n_err = 0;

    namuru_evt_ctrl #(.csr_addr(BANK), .NEV(NEV), .DEPTH(DEPTH)) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .csr_a   (a),
        .csr_we  (we),
        .csr_di  (di),
        .csr_do  (csr_do),
        .ev_in   (ev),
        .irq     (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: architectural registers plus the history of sampled
    // ev_in levels. The synchronized view of a source at edge n is the level
    // sampled DEPTH edges earlier.
    logic [31:0]    m_ts;
    logic           m_en;
    logic [NEV-1:0] m_mask, m_pend, m_pol;
    logic [15:0]    m_ovr;
    logic [31:0]    m_evts [NEV];
    logic [31:0]    m_do;
    logic           m_irq;
    logic [NEV-1:0] samp [$];

    function automatic logic [31:0] m_read(input logic [3:0] i);
        logic [31:0] v;
        v = '0;
        if (i == 4'd0) v[0] = m_en;
        else if (i == 4'd1) v[NEV-1:0] = m_mask;
        else if (i == 4'd2) v[NEV-1:0] = m_pend;
        else if (i == 4'd3) v[15:0] = m_ovr;
        else if (i == 4'd4) v = m_ts;
        else if (i == 4'd5) v[NEV-1:0] = m_pol;
        else if (i >= 4'd8 && int'(i) - 8 < int'(NEV)) v = m_evts[int'(i) - 8];
        return v;
    endfunction

    task automatic model_step();
        int n;
        logic [NEV-1:0] cur, prv, edges, evs, clr;
        logic wsel, sel;
        logic [3:0] i;
        if (rst) begin
            m_ts = '0; m_en = 0; m_mask = '0; m_pend = '0; m_pol = '0;
            m_ovr = '0; m_do = '0; m_irq = 0;
            for (int k = 0; k < NEV; k++) m_evts[k] = '0;
            samp.delete();
        end else begin
            n   = samp.size();
            cur = (n >= int'(DEPTH)) ? samp[n - DEPTH] : '0;
            prv = (n >= int'(DEPTH) + 1) ? samp[n - DEPTH - 1] : '0;
            for (int k = 0; k < NEV; k++)
                edges[k] = m_pol[k] ? (!cur[k] && prv[k]) : (cur[k] && !prv[k]);
            sel  = (a[13:10] == BANK);
            i    = a[3:0];
            wsel = we && sel;
            m_do  = sel ? m_read(i) : 32'd0;
            m_irq = |(m_pend & m_mask);
            clr = (wsel && i == 4'd2) ? di[NEV-1:0] : '0;
            evs = m_en ? edges : '0;
            if (wsel && i == 4'd3) m_ovr = '0;
            else if ((|(evs & m_pend & ~clr)) && m_ovr != 16'hFFFF) m_ovr = m_ovr + 1;
            m_pend = (m_pend & ~clr) | evs;
            for (int k = 0; k < NEV; k++) if (evs[k]) m_evts[k] = m_ts;
            m_ts = (wsel && i == 4'd0 && di[1]) ? 32'd0 : m_ts + 1;
            if (wsel && i == 4'd0) m_en = di[0];
            if (wsel && i == 4'd1) m_mask = di[NEV-1:0];
`ifdef NAMURU_EVT_POL_EN
            if (wsel && i == 4'd5) m_pol = di[NEV-1:0];
`endif
            samp.push_back(ev);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("csr_do", csr_do, m_do);
        chk("irq", {31'd0, irq}, {31'd0, m_irq});
    endtask

    function automatic logic [13:0] addr(input logic [3:0] bank, input logic [3:0] i);
        return {bank, 6'd0, i};
    endfunction

    task automatic rd(input logic [3:0] i, output logic [31:0] v);
        a = addr(BANK, i); we = 0;
        tick();
        v = csr_do;
    endtask

    task automatic wr(input logic [3:0] i, input logic [31:0] d);
        a = addr(BANK, i); we = 1; di = d;
        tick();
        we = 0; di = '0;
    endtask

    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++) tick();
    endtask

    initial begin
        logic [31:0] v, v2;
        logic [3:0]  ri;
        rst = 1; a = '0; we = 0; di = '0; ev = '0;
        idle(2);
        rst = 0;

        // reset state
        for (int i = 0; i < 10; i++) begin
            if (i == 4 || i == 5 || i == 6 || i == 7) continue;
            ri = 4'(i);
            rd(ri, v);
            chk($sformatf("reset_reg%0d", i), v, 32'd0);
        end
        chk("reset_irq", {31'd0, irq}, 32'd0);
        rd(REG_TIMESTAMP, v);
        idle(2);
        rd(REG_TIMESTAMP, v2);
        chk("ts_delta3", v2 - v, 32'd3);

        // single event on source 0, latency and W1C
        wr(REG_CTRL, 32'd1);
        wr(REG_MASK, 32'd1);
        a = addr(BANK, REG_PENDING);
        ev = 2'b01;
        tick();
        ev = 2'b00;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 4) begin
                chk("lat_pend_t4", csr_do, 32'd0);
                chk("lat_irq_t4", {31'd0, irq}, 32'd0);
            end
            if (i == 5) begin
                chk("lat_pend_t5", csr_do, 32'd1);
                chk("lat_irq_t5", {31'd0, irq}, 32'd1);
            end
        end
        rd(REG_EVTS_BASE, v);
        wr(REG_PENDING, 32'd1);
        chk("w1c_irq_same", {31'd0, irq}, 32'd1);
        tick();
        chk("w1c_irq_next", {31'd0, irq}, 32'd0);

        // three pulses on source 1 with MASK=0
        wr(REG_MASK, 32'd0);
        for (int p = 0; p < 3; p++) begin
            ev = 2'b10; tick();
            ev = 2'b00; idle(3);
        end
        idle(6);
        rd(REG_PENDING, v); chk("ovr_pending", v, 32'd2);
        rd(REG_OVERRUN, v); chk("ovr_count", v, 32'd2);
        chk("ovr_irq_masked", {31'd0, irq}, 32'd0);
        wr(REG_OVERRUN, 32'h0);
        rd(REG_OVERRUN, v); chk("ovr_cleared", v, 32'd0);

        // W1C in the same cycle as a new edge: set wins, no overrun
        ev = 2'b01; tick(); ev = 2'b00; idle(7);
        ev = 2'b01; tick();
        ev = 2'b00; idle(3);
        wr(REG_PENDING, 32'd1);
        rd(REG_PENDING, v); chk("setwins_pending", v, 32'd3);
        rd(REG_OVERRUN, v); chk("setwins_overrun", v, 32'd0);

        // disabled: edges discarded; enabling on a held level makes no event
        wr(REG_CTRL, 32'd0);
        ev = 2'b11; tick(); ev = 2'b00; idle(8);
        rd(REG_PENDING, v); chk("dis_pending", v, 32'd3);
        rd(REG_OVERRUN, v); chk("dis_overrun", v, 32'd0);
        ev = 2'b11; idle(8);
        wr(REG_CTRL, 32'd1);
        idle(8);
        rd(REG_PENDING, v); chk("en_held_pending", v, 32'd3);
        rd(REG_OVERRUN, v); chk("en_held_overrun", v, 32'd0);
        ev = 2'b00; idle(8);
        rd(REG_OVERRUN, v); chk("fall_no_event", v, 32'd0);

        // polarity
        wr(REG_PENDING, 32'd3);
`ifdef NAMURU_EVT_POL_EN
        wr(REG_POL, 32'd1);
        rd(REG_POL, v); chk("pol_rw", v, 32'd1);
        ev = 2'b01; idle(8);
        rd(REG_PENDING, v); chk("pol_rise_ignored", v, 32'd0);
        ev = 2'b00; idle(4);
        rd(REG_PENDING, v); chk("pol_fall_t4", v, 32'd0);
        rd(REG_PENDING, v); chk("pol_fall_t5", v, 32'd1);
        wr(REG_POL, 32'd0);
        wr(REG_PENDING, 32'd3);
`else
        wr(REG_POL, 32'd1);
        rd(REG_POL, v); chk("pol_absent", v, 32'd0);
`endif

        // bank select
        a = addr(4'h5, REG_MASK); we = 1; di = 32'd3;
        tick();
        we = 0; di = '0;
        rd(REG_MASK, v); chk("bank_write_ignored", v, 32'd0);
        a = addr(4'h5, REG_TIMESTAMP);
        tick();
        chk("bank_read_zero", csr_do, 32'd0);
        rd(4'd7, v); chk("unmapped_zero", v, 32'd0);

        // randomized traffic against the model, with occasional resets
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 499) == 0);
            for (int k = 0; k < NEV; k++)
                if ($urandom_range(0, 3) == 0) ev[k] = ~ev[k];
            ri = 4'($urandom_range(0, 15));
            a  = {($urandom_range(0, 7) == 0) ? 4'($urandom) : BANK, 6'($urandom), ri};
            we = ($urandom_range(0, 5) == 0);
            di = $urandom;
            if (ri == 4'd0) di[0] = ($urandom_range(0, 3) != 0);
            tick();
        end
        rst = 0; we = 0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
